// File: rtl/sat_accum_pkg.sv
// Shared definitions for the saturating accumulator: FSM state encoding and
// the beat-counter width helper.
package sat_accum_pkg;

  // One-hot is not needed here; a compact binary encoding is sufficient.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Counter must be able to hold the value COUNT_N itself.
  function automatic int unsigned cnt_width(input int unsigned count_n);
    return $clog2(count_n + 1);
  endfunction

endpackage

// File: rtl/sat_add.sv
// sat_add: combinational (ACC_W+1)-bit add of an accumulator and a sample,
// clamped to the representable range of ACC_W bits.
// Ports:
//   a    in  ACC_W   current accumulator value
//   b    in  DATA_W  input sample
//   sum  out ACC_W   clamped result
//   sat  out 1       clamping took place
// Build option: SAT_ACCUM_SIGNED_EN selects two's complement operands with
// clamping at both bounds; otherwise operands are unsigned and only the
// upper bound clamps.
module sat_add #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ACC_W  = 8
) (
  input  logic [ACC_W-1:0]  a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  sum,
  output logic              sat
);

  localparam int unsigned EXT_W = ACC_W + 1;

  logic [EXT_W-1:0] a_ext;
  logic [EXT_W-1:0] b_ext;
  logic [EXT_W-1:0] sum_ext;

`ifdef SAT_ACCUM_SIGNED_EN
  // Sign-extend both operands; the extra bit catches overflow in either direction.
  always_comb begin
    a_ext   = {a[ACC_W-1], a};
    b_ext   = {{(EXT_W-DATA_W){b[DATA_W-1]}}, b};
    sum_ext = a_ext + b_ext;
    sat     = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
    sum     = sum_ext[ACC_W-1:0];
    if (sat) begin
      // Sign of the wide result tells which bound was crossed.
      sum = sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                           : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  // Zero-extend; a carry into the extra bit means the upper bound was crossed.
  always_comb begin
    a_ext   = {1'b0, a};
    b_ext   = {{(EXT_W-DATA_W){1'b0}}, b};
    sum_ext = a_ext + b_ext;
    sat     = sum_ext[ACC_W];
    sum     = sat ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
  end
`endif

endmodule

// File: rtl/sat_accum_fsm.sv
// sat_accum_fsm: on a start pulse, sums exactly COUNT_N accepted input beats
// with saturation, then presents the sum and a sticky overflow flag until the
// consumer takes it.
// Ports:
//   clk, rst   clock (rising edge), asynchronous active-high reset
//   start      begin a run (only honoured in IDLE)
//   in_valid / in_ready / in_data    input beat handshake (ready only in ACCUM)
//   out_valid / out_ready / out_sum / out_ovf   result handshake (valid only in DONE)
//   busy       high whenever the FSM is not in IDLE
// Build option: SAT_ACCUM_SIGNED_EN (handled in sat_add) switches to
// two's complement arithmetic.
module sat_accum_fsm
  import sat_accum_pkg::*;
#(
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned ACC_W   = 8,
  parameter int unsigned COUNT_N = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf,
  output logic              busy
);

  localparam int unsigned       CNT_W    = cnt_width(COUNT_N);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(COUNT_N - 1);

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               ovf;
  logic [ACC_W-1:0]   add_sum;
  logic               add_sat;
  logic               accept;

  assign accept = in_valid && in_ready;

  sat_add #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_sat_add (
    .a   (acc),
    .b   (in_data),
    .sum (add_sum),
    .sat (add_sat)
  );

  // FSM, datapath and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_ACCUM;
            acc      <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            out_sum  <= '0;
            out_ovf  <= 1'b0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ST_ACCUM: begin
          if (accept) begin
            acc <= add_sum;
            ovf <= ovf | add_sat;
            cnt <= cnt + CNT_W'(1);
            // Result is captured on the final beat so it is stable throughout DONE.
            if (cnt == CNT_LAST) begin
              state     <= ST_DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_sum   <= add_sum;
              out_ovf   <= ovf | add_sat;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sat_accum_fsm.sv
// Directed bench for sat_accum_fsm. Two instances share all inputs: an 8-bit
// accumulator (defaults) and a 4-bit one, so overflow and non-overflow results
// are checked from the same stimulus. Inputs change on the falling edge,
// outputs are sampled on the falling edge.
module tb_sat_accum_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] in_data = 4'd0;

  logic       ir8, ov8, of8, b8;
  logic [7:0] s8;
  logic       ir4, ov4, of4, b4;
  logic [3:0] s4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sat_accum_fsm #(.DATA_W(4), .ACC_W(8), .COUNT_N(4)) u_dut8 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(ir8),
    .in_data(in_data), .out_valid(ov8), .out_ready(out_ready), .out_sum(s8),
    .out_ovf(of8), .busy(b8)
  );

  sat_accum_fsm #(.DATA_W(4), .ACC_W(4), .COUNT_N(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(ir4),
    .in_data(in_data), .out_valid(ov4), .out_ready(out_ready), .out_sum(s4),
    .out_ovf(of4), .busy(b4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ir8"}, 32'(ir8), 32'd0);
    check({tag, "_ov8"}, 32'(ov8), 32'd0);
    check({tag, "_b8"},  32'(b8),  32'd0);
    check({tag, "_ir4"}, 32'(ir4), 32'd0);
    check({tag, "_ov4"}, 32'(ov4), 32'd0);
    check({tag, "_b4"},  32'(b4),  32'd0);
  endtask

  task automatic do_start(input string tag);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check({tag, "_st_ir8"},  32'(ir8), 32'd1);
    check({tag, "_st_b4"},   32'(b4),  32'd1);
    check({tag, "_st_of4"},  32'(of4), 32'd0);
    check({tag, "_st_ov8"},  32'(ov8), 32'd0);
  endtask

  task automatic beat(input logic [3:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic gap(input string tag);
    in_valid = 1'b0;
    in_data  = 4'hF;
    @(negedge clk);
    check({tag, "_gap_ir8"}, 32'(ir8), 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [7:0] e8, input logic eo8,
                              input logic [3:0] e4, input logic eo4);
    check({tag, "_ov8"},  32'(ov8), 32'd1);
    check({tag, "_sum8"}, 32'(s8),  32'(e8));
    check({tag, "_ovf8"}, 32'(of8), 32'(eo8));
    check({tag, "_ov4"},  32'(ov4), 32'd1);
    check({tag, "_sum4"}, 32'(s4),  32'(e4));
    check({tag, "_ovf4"}, 32'(of4), 32'(eo4));
    check({tag, "_ir8"},  32'(ir8), 32'd0);
  endtask

  task automatic finish_hs(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_idle({tag, "_hs"});
  endtask

  task automatic run4(input string tag, input logic [3:0] d0, input logic [3:0] d1,
                      input logic [3:0] d2, input logic [3:0] d3,
                      input logic [7:0] e8, input logic eo8,
                      input logic [3:0] e4, input logic eo4);
    do_start(tag);
    beat(d0);
    beat(d1);
    beat(d2);
    check({tag, "_early_ov8"}, 32'(ov8), 32'd0);
    beat(d3);
    check_result(tag, e8, eo8, e4, eo4);
    finish_hs(tag);
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    check_idle("rst");
    check("rst_sum8", 32'(s8), 32'd0);
    check("rst_of8",  32'(of8), 32'd0);
    check("rst_sum4", 32'(s4), 32'd0);
    check("rst_of4",  32'(of4), 32'd0);
    rst = 1'b0;
    @(negedge clk);

`ifdef SAT_ACCUM_SIGNED_EN
    // Lower and upper bound clamping on the narrow instance.
    run4("s_neg", 4'h8, 4'h8, 4'h0, 4'h0, 8'hF0, 1'b0, 4'h8, 1'b1);
    run4("s_pos", 4'h7, 4'h1, 4'h0, 4'h0, 8'h08, 1'b0, 4'h7, 1'b1);
`else
    // Basic sum, no overflow.
    run4("t1", 4'd3, 4'd3, 4'd3, 4'd3, 8'd12, 1'b0, 4'd12, 1'b0);
    // Saturation on the narrow instance; flag persists into IDLE, clears on start.
    run4("t2a", 4'd15, 4'd15, 4'd1, 4'd0, 8'd31, 1'b0, 4'd15, 1'b1);
    check("t2_of4_hold", 32'(of4), 32'd1);
    run4("t2b", 4'd1, 4'd1, 4'd1, 4'd1, 8'd4, 1'b0, 4'd4, 1'b0);

    // Gapped input handshake and back-pressured output.
    do_start("t3");
    beat(4'd2);
    gap("t3");
    beat(4'd5);
    gap("t3");
    gap("t3");
    beat(4'd9);
    gap("t3");
    check("t3_early_ov8", 32'(ov8), 32'd0);
    beat(4'd4);
    check_result("t3", 8'd20, 1'b0, 4'd15, 1'b1);
    in_valid = 1'b1;
    in_data  = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_hold_ov8",  32'(ov8), 32'd1);
      check("t3_hold_sum8", 32'(s8),  32'd20);
      check("t3_hold_sum4", 32'(s4),  32'd15);
    end
    in_valid = 1'b0;
    finish_hs("t3");

    // start held through ACCUM and the DONE handshake cycle is ignored.
    do_start("t5");
    start = 1'b1;
    beat(4'd1);
    beat(4'd2);
    check("t5_busy_acc", 32'(b8), 32'd1);
    beat(4'd3);
    beat(4'd4);
    check_result("t5", 8'd10, 1'b0, 4'd10, 1'b0);
    check("t5_busy_done", 32'(b8), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b0;
    check_idle("t5_hs");
    @(negedge clk);
    check_idle("t5_after");
`endif

    // Mid-run reset aborts immediately, then a clean run follows.
    do_start("t4");
    beat(4'd1);
    beat(4'd1);
    rst = 1'b1;
    #1;
    check_idle("t4_abort");
    check("t4_sum8", 32'(s8), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("t4_post");
    run4("t4b", 4'd1, 4'd1, 4'd1, 4'd1, 8'd4, 1'b0, 4'd4, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #20000;
    failures++;
    $display("FAIL timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
